// File: rtl/debouncer_array.sv
// rtl/debouncer_array.sv - per-channel input debouncer with edge pulses and long-press flag
//
// Parameters:
//   N_CH          number of independent channels (1..32)
//   DEBOUNCE_TIME stable cycles before clean_out follows the input
//   HOLD_TIME     cycles of clean high before hold_out asserts
//   CNT_W         counter width, 2^CNT_W > max(DEBOUNCE_TIME, HOLD_TIME)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   noisy_in    raw per-channel inputs
//   clean_out   debounced level per channel
//   rise_pulse  one-cycle pulse on clean_out 0->1
//   fall_pulse  one-cycle pulse on clean_out 1->0
//   hold_out    long-press flag per channel
//   any_event   registered OR of all rise/fall pulses
// Configuration:
//   DEBOUNCER_SYNC_EN  when defined, a two-flop synchronizer precedes each channel

module debouncer_array #(
    parameter int N_CH          = 4,
    parameter int DEBOUNCE_TIME = 27000,
    parameter int HOLD_TIME     = 2700000,
    parameter int CNT_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] hold_out,
    output logic            any_event
);

    localparam logic [CNT_W-1:0] DT_C = CNT_W'(DEBOUNCE_TIME);
    localparam logic [CNT_W-1:0] HT_C = CNT_W'(HOLD_TIME);

    logic [N_CH-1:0] in_s;

`ifdef DEBOUNCER_SYNC_EN
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= noisy_in;
            sync2 <= sync1;
        end
    end

    assign in_s = sync2;
`else
    assign in_s = noisy_in;
`endif

    logic [N_CH-1:0]  smp;
    logic [N_CH-1:0]  smp_n;
    logic [CNT_W-1:0] dcnt   [N_CH];
    logic [CNT_W-1:0] dcnt_n [N_CH];
    logic [CNT_W-1:0] hcnt   [N_CH];
    logic [CNT_W-1:0] hcnt_n [N_CH];
    logic [N_CH-1:0]  clean_n;
    logic [N_CH-1:0]  hold_n;

    always_comb begin
        smp_n   = smp;
        clean_n = clean_out;
        hold_n  = '0;
        for (int i = 0; i < N_CH; i++) begin
            dcnt_n[i] = dcnt[i];
            hcnt_n[i] = hcnt[i];

            // Any difference from the last sample restarts the stability window.
            if (in_s[i] != smp[i]) begin
                smp_n[i]  = in_s[i];
                dcnt_n[i] = '0;
            end else if (dcnt[i] < DT_C) begin
                dcnt_n[i] = dcnt[i] + CNT_W'(1);
            end else begin
                clean_n[i] = smp[i];
            end

            // Hold counter runs off the registered clean level, so it starts
            // counting the edge after the rise and clears the edge after the fall.
            if (!clean_out[i]) begin
                hcnt_n[i] = '0;
            end else if (hcnt[i] < HT_C) begin
                hcnt_n[i] = hcnt[i] + CNT_W'(1);
            end

            // Gated by clean_out so HOLD_TIME=0 cannot flag an idle channel.
            hold_n[i] = clean_out[i] && (hcnt_n[i] == HT_C);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp        <= '0;
            clean_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
            hold_out   <= '0;
            any_event  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            smp        <= smp_n;
            clean_out  <= clean_n;
            rise_pulse <= clean_n & ~clean_out;
            fall_pulse <= ~clean_n & clean_out;
            hold_out   <= hold_n;
            any_event  <= |(rise_pulse | fall_pulse);
            for (int i = 0; i < N_CH; i++) begin
                dcnt[i] <= dcnt_n[i];
                hcnt[i] <= hcnt_n[i];
            end
        end
    end

endmodule
